// File: rtl/lbll_equiv_checker.sv
// lbll_equiv_checker: drives seeded LFSR stimulus to a golden and a locked DUT and counts output mismatches.
// Optional LBLL_STOP_ON_FAIL_EN ends the run at the first mismatching trial.
module lbll_equiv_checker #(
    parameter int          STIM_W      = 64,
    parameter int          DATA_W      = 64,
    parameter int          NUM_TRIALS  = 30,
    parameter int          WAIT_CYCLES = 50,
    parameter int          RST_CYCLES  = 2,
    parameter logic [31:0] SEED        = 32'h00000001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              dut_rst,
    output logic [STIM_W-1:0] stim,
    output logic              mode,
    input  logic [DATA_W-1:0] gold_data,
    input  logic              gold_valid,
    input  logic [DATA_W-1:0] mod_data,
    input  logic              mod_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       fail_cnt,
    output logic [15:0]       trial_cnt
);
    localparam int          NW        = (STIM_W + 31) / 32;
    localparam logic [31:0] SEED_V    = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
    localparam logic [31:0] LOAD_LAST = 32'(NW - 1);
    localparam logic [31:0] WAIT_LAST = 32'(WAIT_CYCLES - 1);
`ifdef LBLL_STOP_ON_FAIL_EN
    localparam logic STOP_ON_FAIL = 1'b1;
`else
    localparam logic STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_DRST, S_LOAD, S_WAIT, S_CMP, S_DONE} state_t;

    state_t            state, state_nx;
    logic [31:0]       lfsr, lfsr_nx, cnt;
    logic [STIM_W-1:0] stim_ld;
    logic [15:0]       trial_nx;
    logic              mismatch, last_trial;

    assign lfsr_nx    = (lfsr >> 1) ^ (lfsr[0] ? 32'h80200003 : 32'h0);
    assign mismatch   = {gold_valid, gold_data} != {mod_valid, mod_data};
    assign trial_nx   = trial_cnt + 16'd1;
    assign last_trial = (trial_nx == 16'(NUM_TRIALS)) || (STOP_ON_FAIL && mismatch);

    // New LFSR word enters the LSBs; the oldest word falls off the top.
    generate
        if (STIM_W > 32) begin : g_wide
            assign stim_ld = {stim[STIM_W-33:0], lfsr_nx};
        end else begin : g_narrow
            assign stim_ld = lfsr_nx[STIM_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: state_nx = start ? S_DRST : state;
            S_DRST:         state_nx = (cnt == RST_LAST) ? S_LOAD : S_DRST;
            S_LOAD:         state_nx = (cnt == LOAD_LAST) ? S_WAIT : S_LOAD;
            S_WAIT:         state_nx = (cnt == WAIT_LAST) ? S_CMP : S_WAIT;
            S_CMP:          state_nx = last_trial ? S_DONE : S_LOAD;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        dut_rst = state == S_DRST;
        busy    = state inside {S_DRST, S_LOAD, S_WAIT, S_CMP};
        done    = state == S_DONE;
        pass    = done && (fail_cnt == 16'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr      <= SEED_V;
            stim      <= '0;
            mode      <= 1'b0;
            fail_cnt  <= 16'd0;
            trial_cnt <= 16'd0;
            cnt       <= 32'd0;
        end else begin
            cnt <= (state_nx != state) ? 32'd0 : cnt + 32'd1;
            if ((state == S_IDLE || state == S_DONE) && start) begin
                lfsr      <= SEED_V;
                mode      <= 1'b0;
                fail_cnt  <= 16'd0;
                trial_cnt <= 16'd0;
            end
            if (state == S_LOAD) begin
                lfsr <= lfsr_nx;
                stim <= stim_ld;
                mode <= mode ^ (cnt == 32'd0);
            end
            if (state == S_CMP) begin
                trial_cnt <= trial_nx;
                fail_cnt  <= fail_cnt + 16'(mismatch && fail_cnt != 16'hFFFF);
            end
        end
    end
endmodule

// File: tb/tb_lbll_equiv_checker.sv
// tb_lbll_equiv_checker: randomized-gold directed runs checked against an LFSR/trial reference model.
// Honours LBLL_STOP_ON_FAIL_EN when computing expected trial and fail counts.
module tb_lbll_equiv_checker;
    localparam int T = 30;
    localparam int RC = 2;
    localparam int WC = 50;
    localparam int NWORDS = 2;
`ifdef LBLL_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, dut_rst, mode, busy, done, pass, gold_valid, mod_valid;
    logic [63:0] stim, gold_data, mod_data, gold_mask;
    logic [15:0] fail_cnt, trial_cnt, tr;
    logic [31:0] words [2*T];
    int          scen, total, bad;

    always #5 clk = ~clk;

    lbll_equiv_checker #(
        .STIM_W(64), .DATA_W(64), .NUM_TRIALS(T), .WAIT_CYCLES(WC),
        .RST_CYCLES(RC), .SEED(32'h00000001)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dut_rst(dut_rst), .stim(stim), .mode(mode),
        .gold_data(gold_data), .gold_valid(gold_valid), .mod_data(mod_data), .mod_valid(mod_valid),
        .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt), .trial_cnt(trial_cnt)
    );

    // Golden DUT stand-in: stimulus mixed with a random mask; locked copy optionally corrupted.
    assign gold_data  = stim ^ gold_mask ^ {64{mode}};
    assign gold_valid = 1'b1;
    always_comb begin
        tr = trial_cnt + 16'd1;
        mod_data  = gold_data ^ {63'd0, (scen == 1 && tr[0]) || (scen == 3 && tr == 16'd3)};
        mod_valid = gold_valid ^ (scen == 2 && tr == 16'd5);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit mism(input int s, input int k);
        return (s == 1) ? (k % 2 == 1) : (s == 2) ? (k == 5) : (s == 3) ? (k == 3) : 1'b0;
    endfunction

    task automatic do_run(input int s, input int pulse_at, input int abort_at);
        int e, exp_tr, exp_fail;
        bit aborted;
        exp_tr = T;
        exp_fail = 0;
        for (int k = 1; k <= T; k++) begin
            if (mism(s, k)) begin
                exp_fail++;
                if (STOP) begin
                    exp_tr = k;
                    break;
                end
            end
        end
        scen = s;
        aborted = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        e = 0;
        while (!done && e < 4000) begin
            if (e == 0) begin
                chk("busy_start", busy, 1'b1);
                chk("dut_rst_on", dut_rst, 1'b1);
            end
            if (e == RC - 1) chk("dut_rst_hold", dut_rst, 1'b1);
            if (e == RC) chk("dut_rst_off", dut_rst, 1'b0);
            if (e >= RC + NWORDS + 1 && (e - RC - NWORDS - 1) % (NWORDS + WC + 1) == 0
                && (e - RC - NWORDS - 1) / (NWORDS + WC + 1) < exp_tr) begin
                int t;
                t = (e - RC - NWORDS - 1) / (NWORDS + WC + 1);
                chk($sformatf("stim_t%0d", t + 1), stim, {words[2*t], words[2*t+1]});
                chk($sformatf("mode_t%0d", t + 1), mode, (t % 2 == 0));
            end
            if (e == abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk("abort_busy", busy, 1'b0);
                chk("abort_trial", trial_cnt, 16'd0);
                chk("abort_stim", stim, 64'd0);
                chk("abort_mode", mode, 1'b0);
                @(negedge clk);
                chk("abort_done", {done, pass, dut_rst}, 3'b000);
                chk("abort_fail", fail_cnt, 16'd0);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            start = (e == pulse_at);
            gold_mask = {$urandom, $urandom};
            @(negedge clk);
            e++;
        end
        start = 1'b0;
        if (!aborted) begin
            chk("done_cycle", 64'(e + 1), 64'(1 + RC + exp_tr * (NWORDS + WC + 1)));
            chk("done", done, 1'b1);
            chk("busy_end", busy, 1'b0);
            chk("trial_cnt", trial_cnt, 64'(exp_tr));
            chk("fail_cnt", fail_cnt, 64'(exp_fail));
            chk("pass", pass, exp_fail == 0);
        end
    endtask

    initial begin
        logic [31:0] x;
        total = 0;
        bad = 0;
        x = 32'd1;
        for (int i = 0; i < 2 * T; i++) begin
            x = (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
            words[i] = x;
        end
        rst = 1'b1;
        start = 1'b0;
        scen = 0;
        gold_mask = 64'd0;
        repeat (3) @(negedge clk);
        chk("rst_flags", {busy, done, pass, dut_rst, mode}, 5'd0);
        chk("rst_stim", stim, 64'd0);
        chk("rst_cnts", {fail_cnt, trial_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("first_words", {words[0], words[1]}, 64'h80200003_C0300002);
        do_run(0, -1, -1);
        do_run(1, 100, -1);
        do_run(2, -1, -1);
        do_run(3, -1, -1);
        do_run(0, -1, RC + NWORDS + 1 + 9 * (NWORDS + WC + 1) + 10);
        do_run(0, -1, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
